// File: rtl/mem_dump_unit_if.sv
// mem_dump_unit_if: control handshake, memory read port and output stream of mem_dump_unit.
interface mem_dump_unit_if #(parameter int ADDR_W = 8, parameter int DATA_W = 32);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] checksum;
    modport master (
        input  start, base_addr, word_count, mem_rd_data, out_ready,
        output busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_addr, checksum
    );
    modport slave (
        output start, base_addr, word_count, mem_rd_data, out_ready,
        input  busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_addr, checksum
    );
endinterface

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: streams a word-address range of data memory out as {addr, data} over valid/ready.
// Define MEM_DUMP_CHECKSUM_EN to build the running checksum; otherwise checksum is tied to 0.
module mem_dump_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic             clk,
    input logic             rst,
    mem_dump_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            addr_q, addr_d, fly_addr_q, fly_addr_d;
    logic [ADDR_W:0]              rem_q, rem_d;
    logic                         fly_q, fly_d;
    logic [1:0][ADDR_W-1:0]       fa_q, fa_d;
    logic [1:0][DATA_W-1:0]       fd_q, fd_d;
    logic                         wp_q, wp_d, rp_q, rp_d;
    logic [1:0]                   cnt_q, cnt_d;
    logic                         accept, pop, issue;

    assign accept = state_q == IDLE && bus.start;
    assign pop    = bus.out_valid && bus.out_ready;
    // Count the returning read as already occupying a slot so the FIFO can never overflow.
    assign issue  = state_q == READ && (3'(cnt_q) + 3'(fly_q) - 3'(pop)) < 3'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = bus.word_count == '0 ? DONE : READ;
            READ:    if (issue && rem_q == 1) state_d = DRAIN;
            DRAIN:   if (!fly_q && cnt_q == 2'(pop)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = state_q == READ || state_q == DRAIN;
        bus.done      = state_q == DONE;
        bus.mem_rd_en = issue;
        bus.mem_addr  = addr_q;
        bus.out_valid = cnt_q != 0;
        bus.out_data  = fd_q[rp_q];
        bus.out_addr  = fa_q[rp_q];
    end

    always_comb begin
        addr_d     = accept ? bus.base_addr : addr_q + ADDR_W'(issue);
        rem_d      = accept ? bus.word_count : rem_q - (ADDR_W+1)'(issue);
        fly_d      = issue;
        fly_addr_d = addr_q;
        fa_d       = fa_q;
        fd_d       = fd_q;
        if (fly_q) begin
            fa_d[wp_q] = fly_addr_q;
            fd_d[wp_q] = bus.mem_rd_data;
        end
        wp_d  = wp_q ^ fly_q;
        rp_d  = rp_q ^ pop;
        cnt_d = cnt_q + 2'(fly_q) - 2'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            rem_q      <= '0;
            fly_q      <= 1'b0;
            fly_addr_q <= '0;
            fa_q       <= '0;
            fd_q       <= '0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            fly_q      <= fly_d;
            fly_addr_q <= fly_addr_d;
            fa_q       <= fa_d;
            fd_q       <= fd_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    always_comb sum_d = accept ? '0 : sum_q + (pop ? bus.out_data : '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end
    assign bus.checksum = sum_q;
`else
    assign bus.checksum = '0;
`endif
endmodule

// File: doc/mem_dump_unit.md
# mem_dump_unit

Debug readback engine for the pipeline's data memory. On a start pulse it walks a contiguous range of word addresses through the memory's synchronous read port and streams each word, tagged with its address, out over a valid/ready interface. The bench, or a future debug UART/JTAG bridge, uses it to read back architectural results after a program runs, replacing hierarchical peeks into the memory array. It sits beside the Memory stage on a dedicated read port and never drives the pipeline's own load/store path.

## Interface
- ADDR_W, 8, word-address width; the range wraps modulo 2^ADDR_W
- DATA_W, 32, memory word width
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; latched when start is accepted
- word_count  in  ADDR_W+1  number of words to dump, 0 to 2^ADDR_W; latched with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the dump completes
- mem_rd_en  out  1  read strobe to the memory port
- mem_addr  out  ADDR_W  read address; valid when mem_rd_en is high
- mem_rd_data  in  DATA_W  read data, valid exactly one cycle after mem_rd_en
- out_valid  out  1  stream word available
- out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high
- out_data  out  DATA_W  stream word
- out_addr  out  ADDR_W  address the stream word was read from
- checksum  out  DATA_W  running modulo-2^DATA_W sum of transferred words; see Configuration

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start with word_count > 0 latches base_addr and word_count and moves to READ.
  - start with word_count = 0 moves directly to DONE with no reads.
- READ: issues reads at ascending addresses. Moves to DRAIN in the cycle after the last read issues.
- DRAIN: waits for the in-flight read to return and for the buffer to empty.
- DONE: lasts one cycle, asserts done, then returns to IDLE.
- Buffer: 2-entry FIFO of {addr, data}. A read is issued only when (fifo occupancy + in-flight reads − pop this cycle) < 2, so the FIFO never overflows and no memory data is dropped.
- Address counter increments per issued read. It wraps from 2^ADDR_W−1 to 0.
- out_valid, out_data and out_addr come from the FIFO head. While out_valid is high and out_ready is low, all three hold stable.
- start while busy is ignored.
- checksum clears when start is accepted and adds out_data on every handshake.

## Timing
- Reset value of every output is 0. Reset asserted mid-dump flushes the FIFO, drops any in-flight read and returns the state to IDLE. No done pulse is issued.
- Start sampled in cycle 0:
  - busy and mem_rd_en are high in cycle 1, with mem_addr = base_addr.
  - Data returns in cycle 2, is written to the FIFO at the end of cycle 2, and out_valid rises in cycle 3.
- With out_ready held high, throughput is one word per cycle after the first.
- With out_ready low, at most 2 words are read ahead, then mem_rd_en stays low until a pop.
- If the last handshake occurs in cycle N, done pulses and busy falls in cycle N+1. start is accepted again from cycle N+2.
- word_count = 0: done pulses in cycle 1, and busy and mem_rd_en never rise.

## Configuration
- MEM_DUMP_CHECKSUM_EN defined: the checksum accumulator is built and behaves as described above.
- MEM_DUMP_CHECKSUM_EN undefined: no accumulator logic is built and checksum is tied to 0.

## Test plan
- Memory words 0..3 = 0x11, 0x22, 0x33, 0x44; start with base 0, count 4, out_ready held high -> out_valid from cycle 3, one word per cycle with out_addr 0..3, done in cycle 7, checksum = 0xAA.
- Same memory; out_ready low for 10 cycles after start -> exactly 2 reads issued, then mem_rd_en stays low. Raising out_ready delivers all 4 words in order, none lost or duplicated.
- ADDR_W = 8, base 0xFE, count 4 -> out_addr sequence 0xFE, 0xFF, 0x00, 0x01.
- Start with count 0 -> done in cycle 1, no mem_rd_en, no out_valid, checksum 0.
- Start asserted again during a dump -> ignored; the original dump completes unchanged.
- rst asserted after the second word handshakes -> all outputs 0 in the same cycle, no done pulse. A new start with base 2, count 2 then delivers 0x33, 0x44.
